// File: rtl/tiny_console_tx_pkg.sv
// Shared definitions for the console output stage.
//   - serialiser FSM state encoding
//   - default display-window constants
//   - window-membership helper used by the write snooper
package tiny_console_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } con_state_e;

  localparam logic [7:0] CON_WIN_BASE = 8'd0;
  localparam int         CON_WIN_SIZE = 32;

  // Window is [base, base+size) evaluated in int so it never wraps past 255.
  function automatic logic in_window(input logic [7:0] addr,
                                     input logic [7:0] base,
                                     input int         size);
    return (int'(addr) >= int'(base)) && (int'(addr) < int'(base) + size);
  endfunction

endpackage

// File: rtl/tiny_console_tx_if.sv
// Snooped TINYCPU RAM write bus.
//   ram_addr : 8-bit RAM address
//   ram_wdat : 8-bit write data
//   ram_wr_  : write strobe, active low
// master = CPU side (drives), slave = observers (console tx).
interface tiny_console_tx_if;
  logic [7:0] ram_addr;
  logic [7:0] ram_wdat;
  logic       ram_wr_;

  modport master (output ram_addr, output ram_wdat, output ram_wr_);
  modport slave  (input  ram_addr, input  ram_wdat, input  ram_wr_);
endinterface

// File: rtl/tiny_sync_fifo.sv
// Single-clock circular FIFO.
//   i_clk/i_rst : clock, synchronous active-high reset
//   i_push/i_din: write request and data (ignored when full unless popping)
//   i_pop       : read request (ignored when empty); o_dout shows the head
//   o_full/o_empty/o_count : occupancy status
// A push while full is accepted when a pop happens at the same edge, since
// the slot being freed is the one the write pointer lands on.
module tiny_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_din,
  output logic [WIDTH-1:0]       o_dout,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_count;
  logic             w_push, w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rptr];

  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

endmodule

// File: rtl/tiny_console_tx.sv
// Console output stage: snoops CPU RAM writes into the display window,
// buffers the bytes and shifts them out as 8N1 serial frames.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : snooped RAM write bus (slave modport, never driven)
//   tx        : serial line, idle high
//   busy      : frame in flight or characters queued
//   fifo_full : character FIFO full
//   drop_cnt  : in-window writes lost to a full FIFO, saturating at 255
module tiny_console_tx
  import tiny_console_tx_pkg::*;
#(
  parameter logic [7:0] WIN_BASE     = CON_WIN_BASE,
  parameter int         WIN_SIZE     = CON_WIN_SIZE,
  parameter int         FIFO_DEPTH   = 8,
  parameter int         CLKS_PER_BIT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  tiny_console_tx_if.slave       bus,
  output logic                   tx,
  output logic                   busy,
  output logic                   fifo_full,
  output logic [7:0]             drop_cnt
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);

  con_state_e  r_state;
  logic [CW-1:0] r_bitcnt;
  logic [2:0]  r_bitidx;
  logic [7:0]  r_shreg;
  logic        r_tx, r_busy;
  logic [7:0]  r_drop;

  logic        w_seen, w_pop, w_drop, w_push_acc, w_bit_last;
  logic        w_empty, w_full;
  logic [7:0]  w_head;
  logic [AW:0] w_count, w_cnt_nxt;

  assign w_seen     = !bus.ram_wr_ && in_window(bus.ram_addr, WIN_BASE, WIN_SIZE);
  assign w_bit_last = (r_bitcnt == CW'(CLKS_PER_BIT-1));
  // Pop from IDLE, or on the last stop-bit cycle for gapless back-to-back frames.
  assign w_pop      = !w_empty && ((r_state == ST_IDLE) ||
                                   (r_state == ST_STOP && w_bit_last));
  assign w_drop     = w_seen && w_full && !w_pop;
  assign w_push_acc = w_seen && !w_drop;
  assign w_cnt_nxt  = w_count + (AW+1)'(w_push_acc) - (AW+1)'(w_pop);

  tiny_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_seen),
    .i_pop   (w_pop),
    .i_din   (bus.ram_wdat),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign tx        = r_tx;
  assign busy      = r_busy;
  assign fifo_full = w_full;
  assign drop_cnt  = r_drop;

  // busy is registered from the post-edge state/count so it lines up with tx.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_bitcnt <= '0;
      r_bitidx <= '0;
      r_shreg  <= '0;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
      r_drop   <= '0;
    end else begin
      if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
      r_busy <= (w_cnt_nxt != '0);
      case (r_state)
        ST_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shreg  <= w_head;
            r_bitcnt <= '0;
            r_state  <= ST_START;
            r_tx     <= 1'b0;
            r_busy   <= 1'b1;
          end
        end
        ST_START: begin
          r_busy <= 1'b1;
          if (w_bit_last) begin
            r_bitcnt <= '0;
            r_bitidx <= '0;
            r_state  <= ST_DATA;
            r_tx     <= r_shreg[0];
          end else begin
            r_bitcnt <= r_bitcnt + CW'(1);
          end
        end
        ST_DATA: begin
          r_busy <= 1'b1;
          if (w_bit_last) begin
            r_bitcnt <= '0;
            if (r_bitidx == 3'd7) begin
              r_state <= ST_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bitidx <= r_bitidx + 3'd1;
              r_shreg  <= r_shreg >> 1;
              r_tx     <= r_shreg[1];
            end
          end else begin
            r_bitcnt <= r_bitcnt + CW'(1);
          end
        end
        ST_STOP: begin
          if (w_bit_last) begin
            r_bitcnt <= '0;
            if (w_pop) begin
              r_shreg <= w_head;
              r_state <= ST_START;
              r_tx    <= 1'b0;
              r_busy  <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_tx    <= 1'b1;
            end
          end else begin
            r_bitcnt <= r_bitcnt + CW'(1);
            r_busy   <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/tiny_console_tx.md
Name: tiny_console_tx

Overview:
- Memory-mapped console output stage that sits directly downstream of the TINYCPU RAM write port.
- Snoops the CPU's RAM write bus. Every write that lands in the display window (RAM bytes 0..31) is buffered in a small FIFO.
- Buffered characters are serialised on a UART-style 8N1 line, so program output is visible on real hardware and not only in simulation dumps.
- Purely an observer: never stalls the CPU and never drives the RAM.

Parameters:
- WIN_BASE, 8'd0, first RAM address of the display window.
- WIN_SIZE, 32, number of bytes in the window; accepted range is WIN_BASE <= addr < WIN_BASE+WIN_SIZE, with no wrap past 255.
- FIFO_DEPTH, 8, character FIFO entries; must be a power of 2.
- CLKS_PER_BIT, 4, clock cycles per serial bit; must be >= 2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ram_addr  in  8  CPU RAM address bus (snooped).
- ram_wdat  in  8  CPU RAM write data (snooped).
- ram_wr_  in  1  CPU RAM write strobe, active low (snooped).
- tx  out  1  serial output; idle high.
- busy  out  1  high while a frame is being shifted or the FIFO is non-empty.
- fifo_full  out  1  FIFO count == FIFO_DEPTH.
- drop_cnt  out  8  count of in-window writes lost to a full FIFO; saturates at 255.

Behaviour:
- Reset (rst=1 at a rising edge):
  - FIFO emptied; FSM returns to IDLE.
  - Outputs: tx=1, busy=0, fifo_full=0, drop_cnt=0.
  - Takes effect at that edge even mid-frame; the partial frame is abandoned and tx returns high immediately.
- Capture:
  - A write is "seen" at each rising edge where ram_wr_==0 and ram_addr is inside the window.
  - If the strobe is held low for N edges, that is N writes (the CPU asserts it for one cycle per store).
  - Each seen write pushes ram_wdat; the address is not stored.
- Push acceptance:
  - Accepted if the pre-edge count < FIFO_DEPTH, or a pop occurs at the same edge.
  - Otherwise the byte is discarded and drop_cnt increments, saturating at 255.
- FIFO:
  - Circular buffer; read and write pointers are log2(FIFO_DEPTH) bits and wrap naturally.
  - Count is log2(FIFO_DEPTH)+1 bits.
  - Simultaneous push and pop leaves the count unchanged.
- FSM states: IDLE, START, DATA, STOP. Internal state: bit counter 0..CLKS_PER_BIT-1, bit index 0..7, 8-bit shift register.
  - IDLE: tx=1. If the FIFO is non-empty at an edge, pop the head into the shift register and go to START, so tx=0 from that edge.
    - Latency: a write seen at edge k with an empty FIFO pops at edge k+1, and the start bit begins after edge k+1.
  - START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx = shift register LSB, held CLKS_PER_BIT cycles per bit, then shift right. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
    - Back-to-back frames: if the FIFO is non-empty on the final STOP cycle, pop directly and go to START with no idle gap.
  - Frame length: exactly 10*CLKS_PER_BIT cycles.
- tx is registered; no combinational path from inputs to tx.
- busy = (state != IDLE) or (count != 0), registered.
- Writes outside the window, and cycles with ram_wr_==1, have no effect.

Decomposition:
- Shared package/header (alongside the existing tinyCPU definitions):
  - FSM state encodings: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3.
  - Default window constants CON_WIN_BASE and CON_WIN_SIZE.
- One natural sub-module: tiny_sync_fifo, a synchronous FIFO with push/pop/full/empty/count, parameterised on width and depth.
  - Instantiated once with width 8.
  - The serialiser FSM and the window decode stay in tiny_console_tx.

Test Plan:
- Reset: hold rst=1 for 2 cycles with ram_wr_=0, addr=5 -> tx=1, busy=0, drop_cnt=0, and no frame afterwards.
- Single char (CLKS_PER_BIT=4): write 8'h41 ('A') to addr 3 at edge k -> tx low on cycles k+1..k+4. Data bits 1,0,0,0,0,0,1,0 (LSB first), 4 cycles each. Stop high. Frame 40 cycles; busy falls after the stop bit.
- Window filter: writes to addr 32, 255 and 31 -> only the addr-31 byte is transmitted; drop_cnt=0.
- Overflow: 10 consecutive in-window writes 0x30..0x39 on edges 0..9 (FIFO_DEPTH=8) -> 9 bytes sent back-to-back (0x30..0x38, no idle gaps), 0x39 dropped, drop_cnt=1, fifo_full high after edge 8.
- Reset mid-frame: assert rst during DATA bit 3 of 'A', with 2 bytes queued -> tx=1 the cycle after, FIFO empty, no further frames, drop_cnt=0.
- Saturation: force 300 drops (FIFO held full, continuous writes) -> drop_cnt stops at 255.
